secret_accum_bank: RTL and testbench

Parametrised, multi-channel successor to the single-channel protected accumulator used in the DPI protected-library flow. It holds CHANNELS independent WIDTH-bit accumulators. Each accepted sample adds the sample plus a hidden constant SECRET to the selected channel. A valid/ready input handshake, a registered result stream, a combinational read/bypass port and a multi-cycle clear-all sweep are provided. The block sits behind the protected-library wrapper as the secret implementation; only its ports are visible to the host model.

---
 rtl/secret_accum_bank_if.sv | 34 +++
 rtl/secret_accum_bank.sv | 112 +++++++++++
 tb/tb_secret_accum_bank.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/secret_accum_bank_if.sv
// Bundle of the sample handshake, result stream and read port of secret_accum_bank.
// The master modport is the host side; the slave modport is the accumulator bank.
interface secret_accum_bank_if #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic             in_valid;
    logic             in_ready;
    logic [CW-1:0]    in_chan;
    logic [WIDTH-1:0] in_data;
    logic             in_clear;
    logic             clear_all;
    logic             busy;
    logic             out_valid;
    logic [CW-1:0]    out_chan;
    logic [WIDTH-1:0] out_data;
    logic             out_err;
    logic             out_sat;
    logic [CW-1:0]    rd_chan;
    logic             rd_bypass;
    logic [WIDTH-1:0] rd_data;

    modport master (
        output in_valid, in_chan, in_data, in_clear, clear_all, rd_chan, rd_bypass,
        input  in_ready, busy, out_valid, out_chan, out_data, out_err, out_sat, rd_data
    );

    modport slave (
        input  in_valid, in_chan, in_data, in_clear, clear_all, rd_chan, rd_bypass,
        output in_ready, busy, out_valid, out_chan, out_data, out_err, out_sat, rd_data
    );
endinterface

// File: rtl/secret_accum_bank.sv
// CHANNELS accumulators adding sample+SECRET; 1-cycle result, no output backpressure,
// in_ready low during a clear sweep. Define SECRET_ACCUM_SAT_EN for saturating sums.
module secret_accum_bank #(
    parameter int               WIDTH    = 32,
    parameter int               CHANNELS = 4,
    parameter logic [WIDTH-1:0] SECRET   = WIDTH'(7)
) (
    input logic                clk,
    input logic                rst,
    secret_accum_bank_if.slave bus
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic {RUN, SWEEP} state_t;

    state_t           state_q;
    logic [CW-1:0]    sweep_q;
    logic [WIDTH-1:0] acc_q [CHANNELS];
    logic             out_valid_q;
    logic [CW-1:0]    out_chan_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_err_q;
    logic             out_sat_q;

    logic             in_ready;
    logic             xfer;
    logic             chan_ok;
    logic [WIDTH-1:0] cur_acc;
    logic [WIDTH-1:0] rd_acc;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] sum_d;
    logic             sat_d;

    // Mux-based reads keep out-of-range selects from indexing past the array.
    always_comb begin
        cur_acc = '0;
        rd_acc  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (bus.in_chan == CW'(i)) cur_acc = acc_q[i];
            if (bus.rd_chan == CW'(i)) rd_acc  = acc_q[i];
        end
    end

    assign chan_ok = int'(bus.in_chan) < CHANNELS;
    assign base    = bus.in_clear ? '0 : cur_acc;

`ifdef SECRET_ACCUM_SAT_EN
    logic [WIDTH+1:0] wide_sum;
    assign wide_sum = {2'b00, base} + {2'b00, bus.in_data} + {2'b00, SECRET};
    assign sat_d    = |wide_sum[WIDTH+1:WIDTH];
    assign sum_d    = sat_d ? '1 : wide_sum[WIDTH-1:0];
`else
    assign sum_d = base + bus.in_data + SECRET;
    assign sat_d = 1'b0;
`endif

    assign in_ready = (state_q == RUN) && !bus.clear_all;
    assign xfer     = bus.in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            sweep_q     <= '0;
            out_valid_q <= 1'b0;
            out_chan_q  <= '0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
            out_sat_q   <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) acc_q[i] <= '0;
        end else begin
            out_valid_q <= xfer;
            if (xfer) begin
                out_chan_q <= bus.in_chan;
                out_data_q <= chan_ok ? sum_d : '0;
                out_err_q  <= !chan_ok;
                out_sat_q  <= chan_ok && sat_d;
            end
            case (state_q)
                RUN: begin
                    if (bus.clear_all) begin
                        state_q <= SWEEP;
                        sweep_q <= '0;
                    end
                    for (int i = 0; i < CHANNELS; i++) begin
                        if (xfer && chan_ok && bus.in_chan == CW'(i)) acc_q[i] <= sum_d;
                    end
                end
                SWEEP: begin
                    for (int i = 0; i < CHANNELS; i++) begin
                        if (sweep_q == CW'(i)) acc_q[i] <= '0;
                    end
                    if (int'(sweep_q) == CHANNELS - 1) begin
                        state_q <= RUN;
                        sweep_q <= '0;
                    end else begin
                        sweep_q <= sweep_q + CW'(1);
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.busy      = (state_q == SWEEP);
    assign bus.out_valid = out_valid_q;
    assign bus.out_chan  = out_chan_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_err   = out_err_q;
    assign bus.out_sat   = out_sat_q;
    assign bus.rd_data   = bus.rd_bypass ? bus.in_data : rd_acc;
endmodule

// File: tb/tb_secret_accum_bank.sv
// Directed bench for secret_accum_bank: a 4-channel and a 3-channel instance,
// results checked against a reference model through expected-result queues.
module tb_secret_accum_bank;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    secret_accum_bank_if #(.WIDTH(32), .CHANNELS(4)) bus4 ();
    secret_accum_bank_if #(.WIDTH(32), .CHANNELS(3)) bus3 ();

    secret_accum_bank #(.WIDTH(32), .CHANNELS(4), .SECRET(32'd7)) u_dut4 (
        .clk(clk), .rst(rst), .bus(bus4.slave));
    secret_accum_bank #(.WIDTH(32), .CHANNELS(3), .SECRET(32'd7)) u_dut3 (
        .clk(clk), .rst(rst), .bus(bus3.slave));

    typedef struct packed {
        logic [1:0]  chan;
        logic [31:0] data;
        logic        err;
        logic        sat;
    } exp_t;

    exp_t        q4[$];
    exp_t        q3[$];
    logic [31:0] mdl4 [4];
    logic [31:0] mdl3 [3];
    int          n_cmp = 0;
    int          n_err = 0;
    exp_t        e4, e3;
    int          busy_cnt, nrdy_cnt;
    logic [31:0] old_val;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] acc, input logic [31:0] d,
                                   input logic clr, input logic [1:0] ch);
        logic [33:0] w;
        exp_t e;
        w = {2'b00, (clr ? 32'h0 : acc)} + {2'b00, d} + 34'd7;
        e.chan = ch;
        e.err  = 1'b0;
`ifdef SECRET_ACCUM_SAT_EN
        e.sat  = |w[33:32];
        e.data = e.sat ? 32'hFFFF_FFFF : w[31:0];
`else
        e.sat  = 1'b0;
        e.data = w[31:0];
`endif
        return e;
    endfunction

    task automatic push4(input logic [1:0] ch, input logic [31:0] d, input logic clr);
        exp_t e;
        e = model(mdl4[ch], d, clr, ch);
        mdl4[ch] = e.data;
        q4.push_back(e);
    endtask

    task automatic drive4(input logic [1:0] ch, input logic [31:0] d, input logic clr);
        push4(ch, d, clr);
        bus4.in_valid = 1'b1; bus4.in_chan = ch; bus4.in_data = d; bus4.in_clear = clr;
        @(posedge clk); #1;
        bus4.in_valid = 1'b0; bus4.in_clear = 1'b0;
    endtask

    task automatic drive3(input logic [1:0] ch, input logic [31:0] d);
        exp_t e;
        if (ch >= 2'd3) begin
            e.chan = ch; e.data = '0; e.err = 1'b1; e.sat = 1'b0;
        end else begin
            e = model(mdl3[ch], d, 1'b0, ch);
            mdl3[ch] = e.data;
        end
        q3.push_back(e);
        bus3.in_valid = 1'b1; bus3.in_chan = ch; bus3.in_data = d;
        @(posedge clk); #1;
        bus3.in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (bus4.out_valid) begin
            if (q4.size() == 0) check("unexpected_out4", 64'd1, 64'd0);
            else begin
                e4 = q4.pop_front();
                check("out4_chan", 64'(bus4.out_chan), 64'(e4.chan));
                check("out4_data", 64'(bus4.out_data), 64'(e4.data));
                check("out4_err",  64'(bus4.out_err),  64'(e4.err));
                check("out4_sat",  64'(bus4.out_sat),  64'(e4.sat));
            end
        end
        if (bus3.out_valid) begin
            if (q3.size() == 0) check("unexpected_out3", 64'd1, 64'd0);
            else begin
                e3 = q3.pop_front();
                check("out3_chan", 64'(bus3.out_chan), 64'(e3.chan));
                check("out3_data", 64'(bus3.out_data), 64'(e3.data));
                check("out3_err",  64'(bus3.out_err),  64'(e3.err));
            end
        end
    end

    initial begin
        bus4.in_valid = 0; bus4.in_chan = 0; bus4.in_data = 0; bus4.in_clear = 0;
        bus4.clear_all = 0; bus4.rd_chan = 0; bus4.rd_bypass = 0;
        bus3.in_valid = 0; bus3.in_chan = 0; bus3.in_data = 0; bus3.in_clear = 0;
        bus3.clear_all = 0; bus3.rd_chan = 0; bus3.rd_bypass = 0;
        for (int i = 0; i < 4; i++) mdl4[i] = '0;
        for (int i = 0; i < 3; i++) mdl3[i] = '0;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_in_ready",  64'(bus4.in_ready),  64'd1);
        check("rst_busy",      64'(bus4.busy),      64'd0);
        check("rst_out_valid", 64'(bus4.out_valid), 64'd0);
        check("rst_rd_ch0",    64'(bus4.rd_data),   64'd0);
        @(posedge clk); #1;

        drive4(2'd2, 32'd5, 1'b0);
        drive4(2'd1, 32'd1, 1'b0);
        drive4(2'd1, 32'd2, 1'b0);
        drive4(2'd1, 32'd3, 1'b0);
        drive4(2'd1, 32'd0, 1'b1);
        drive4(2'd0, 32'd1, 1'b0);
        drive4(2'd3, 32'd2, 1'b0);
        @(posedge clk); #1;
        bus4.rd_chan = 2'd2; #1;
        check("rd_ch2_12", 64'(bus4.rd_data), 64'd12);
        bus4.rd_chan = 2'd1; #1;
        check("rd_ch1_7",  64'(bus4.rd_data), 64'd7);

        // 3-channel instance: out-of-range channel
        drive3(2'd0, 32'd1);
        drive3(2'd2, 32'd2);
        drive3(2'd3, 32'd9);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            bus3.rd_chan = 2'(i); #1;
            check("rd3_unchanged", 64'(bus3.rd_data), 64'(mdl3[i]));
        end

        // clear sweep; the sample offered with clear_all must be dropped
        @(posedge clk); #1;
        bus4.clear_all = 1'b1; bus4.in_valid = 1'b1; bus4.in_chan = 2'd0; bus4.in_data = 32'd99;
        #1;
        check("req_in_ready", 64'(bus4.in_ready), 64'd0);
        busy_cnt = 0; nrdy_cnt = 1;
        @(posedge clk); #1;
        bus4.in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            bus4.clear_all = (k == 1);
            @(negedge clk);
            busy_cnt += int'(bus4.busy);
            nrdy_cnt += int'(!bus4.in_ready);
            @(posedge clk); #1;
        end
        bus4.clear_all = 1'b0;
        check("sweep_busy_cycles",  64'(busy_cnt), 64'd4);
        check("sweep_nready_cycles", 64'(nrdy_cnt), 64'd5);
        for (int i = 0; i < 4; i++) begin
            mdl4[i] = '0;
            bus4.rd_chan = 2'(i); #1;
            check("sweep_rd_zero", 64'(bus4.rd_data), 64'd0);
        end

        // overflow on ch0
        drive4(2'd0, 32'hFFFF_FFE9, 1'b1);
        drive4(2'd0, 32'h0000_0010, 1'b0);
`ifdef SECRET_ACCUM_SAT_EN
        check("ovf_data", 64'(bus4.out_data), 64'hFFFF_FFFF);
        check("ovf_sat",  64'(bus4.out_sat),  64'd1);
`else
        check("ovf_data", 64'(bus4.out_data), 64'h0000_0007);
        check("ovf_sat",  64'(bus4.out_sat),  64'd0);
`endif

        // read port: old value until the edge, then bypass
        drive4(2'd2, 32'd3, 1'b0);
        old_val = mdl4[2];
        bus4.rd_chan = 2'd2;
        bus4.in_valid = 1'b1; bus4.in_chan = 2'd2; bus4.in_data = 32'd100; bus4.in_clear = 1'b1;
        push4(2'd2, 32'd100, 1'b1);
        #1;
        check("rd_pre_edge", 64'(bus4.rd_data), 64'(old_val));
        @(posedge clk); #1;
        bus4.in_valid = 1'b0; bus4.in_clear = 1'b0;
        #1;
        check("rd_post_edge", 64'(bus4.rd_data), 64'd107);
        bus4.rd_bypass = 1'b1; bus4.in_data = 32'hDEAD_BEEF; #1;
        check("bypass_a", 64'(bus4.rd_data), 64'hDEAD_BEEF);
        bus4.in_data = 32'h1234_5678; #1;
        check("bypass_b", 64'(bus4.rd_data), 64'h1234_5678);
        bus4.rd_bypass = 1'b0;

        // async reset between edges while a result is showing
        @(posedge clk); #1;
        drive4(2'd3, 32'd55, 1'b0);
        @(negedge clk); #1;
        rst = 1'b1; #1;
        check("arst_out_valid", 64'(bus4.out_valid), 64'd0);
        check("arst_out_data",  64'(bus4.out_data),  64'd0);
        check("arst_out_chan",  64'(bus4.out_chan),  64'd0);
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mdl4[i] = '0;
            bus4.rd_chan = 2'(i); #1;
            check("arst_rd_zero", 64'(bus4.rd_data), 64'd0);
        end
        for (int i = 0; i < 3; i++) mdl3[i] = '0;

        // async reset mid-sweep
        drive4(2'd3, 32'd20, 1'b0);
        @(posedge clk); #1;
        bus4.clear_all = 1'b1;
        @(posedge clk); #1;
        bus4.clear_all = 1'b0;
        @(posedge clk); #2;
        check("sweep_busy_before", 64'(bus4.busy), 64'd1);
        rst = 1'b1; #1;
        check("midsweep_busy",     64'(bus4.busy),     64'd0);
        check("midsweep_in_ready", 64'(bus4.in_ready), 64'd1);
        @(posedge clk); #1 rst = 1'b0; #1;
        check("post_rst_in_ready", 64'(bus4.in_ready), 64'd1);
        bus4.rd_chan = 2'd3; #1;
        check("post_rst_ch3", 64'(bus4.rd_data), 64'd0);

        repeat (2) @(posedge clk);
        #1;
        check("q4_drained", 64'(q4.size()), 64'd0);
        check("q3_drained", 64'(q3.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
